// File: rtl/shorted_cell_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shorted_cell_bank_pkg
// Description : Register offsets, status bit indices and measurement FSM
//               state encoding shared by the shorted cell bank.
// Revision    : 1.0 - initial release
// ============================================================================
package shorted_cell_bank_pkg;

    localparam int unsigned OFS_SPIN  = 0;
    localparam int unsigned OFS_SHORT = 1;
    localparam int unsigned OFS_CTRL  = 2;
    localparam int unsigned OFS_WIN   = 3;
    localparam int unsigned OFS_STAT  = 4;
    localparam int unsigned OFS_AGREE = 8;

    localparam int unsigned CTRL_MEASURE = 0;
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shorted_cell_stage.sv
`default_nettype none
// ============================================================================
// Module      : shorted_cell_stage
// Description : One RO stage: ring-input latches, short/independent output
//               mux and a NUM_LUTS-deep buffer on each output.
// Revision    : 1.0 - initial release
// ============================================================================
module shorted_cell_stage #(
    parameter int NUM_LUTS = 2
) (
    input  logic ising_rstn,
    input  logic start,
    input  logic spin,
    input  logic short_en,
    input  logic sin,
    input  logic din,
    output logic sout,
    output logic dout
);

    logic w_s_int;
    logic w_d_int;
    logic w_nand;
    logic w_s_mux;
    logic w_d_mux;

`ifdef SYNTHESIS
    // Always-open latches cleared by ising_rstn; kept so the ring path is not optimised away
    (* dont_touch = "true" *) LDCE #(.INIT(1'b0)) u_s_latch (
        .Q(w_s_int), .D(sin), .G(1'b1), .GE(1'b1), .CLR(~ising_rstn));
    (* dont_touch = "true" *) LDCE #(.INIT(1'b0)) u_d_latch (
        .Q(w_d_int), .D(din), .G(1'b1), .GE(1'b1), .CLR(~ising_rstn));
`else
    // Behavioural latch: transparent once released, forced low while held
    assign w_s_int = ising_rstn & sin;
    assign w_d_int = ising_rstn & din;
`endif

    // Shorted stages drive both rings with one NAND so they lock in phase
    assign w_nand  = ~(w_s_int & w_d_int);
    assign w_s_mux = start ? (short_en ? w_nand : ~w_s_int) : spin;
    assign w_d_mux = start ? (short_en ? w_nand : ~w_d_int) : spin;

    (* dont_touch = "true" *) logic [NUM_LUTS:0] w_s_buf;
    (* dont_touch = "true" *) logic [NUM_LUTS:0] w_d_buf;

    assign w_s_buf[0] = w_s_mux;
    assign w_d_buf[0] = w_d_mux;

    generate
        for (genvar k = 0; k < NUM_LUTS; k++) begin : g_buf
            assign w_s_buf[k+1] = w_s_buf[k];
            assign w_d_buf[k+1] = w_d_buf[k];
        end
    endgenerate

    assign sout = w_s_buf[NUM_LUTS];
    assign dout = w_d_buf[NUM_LUTS];

endmodule
`default_nettype wire

// File: rtl/shorted_cell_bank.sv
`default_nettype none
// ============================================================================
// Module      : shorted_cell_bank
// Description : Bank of shorted RO stages with register file, s-phase
//               synchronisers and a windowed phase-agreement counter engine.
// Revision    : 1.0 - initial release
// ============================================================================
module shorted_cell_bank
    import shorted_cell_bank_pkg::*;
#(
    parameter int NUM_CELLS = 4,
    parameter int NUM_LUTS  = 2,
    parameter int CNT_W     = 16,
    parameter int ADDR_W    = 6
) (
    input  logic                 clk,
    input  logic                 axi_rstn,
    input  logic                 ising_rstn,
    input  logic                 start,
    input  logic [NUM_CELLS-1:0] sin,
    input  logic [NUM_CELLS-1:0] din,
    output logic [NUM_CELLS-1:0] sout,
    output logic [NUM_CELLS-1:0] dout,
    input  logic                 wready,
    input  logic                 wr_addr_match,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [31:0]          wdata,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [31:0]          rdata
);

    logic [NUM_CELLS-1:0] spin_q;
    logic [NUM_CELLS-1:0] short_q;
    logic [CNT_W-1:0]     win_q;
    logic [NUM_CELLS-1:0] sync1_q;
    logic [NUM_CELLS-1:0] sync_s_q;
    logic [CNT_W-1:0]     wcnt_q;
    logic [CNT_W-1:0]     agree_q [NUM_CELLS];
    logic                 busy_q;
    logic                 done_q;
    state_t               state_q;

    logic w_wr;
    logic w_measure;
    logic w_done_clr;
    logic w_unused;

    assign w_wr       = wready & wr_addr_match;
    assign w_measure  = w_wr && (wr_addr == ADDR_W'(OFS_CTRL)) && wdata[CTRL_MEASURE];
    assign w_done_clr = w_wr && (wr_addr == ADDR_W'(OFS_STAT)) && wdata[STAT_DONE];
    assign w_unused   = ^wdata;

    generate
        for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
            shorted_cell_stage #(
                .NUM_LUTS (NUM_LUTS)
            ) u_stage (
                .ising_rstn (ising_rstn),
                .start      (start),
                .spin       (spin_q[i]),
                .short_en   (short_q[i]),
                .sin        (sin[i]),
                .din        (din[i]),
                .sout       (sout[i]),
                .dout       (dout[i])
            );
        end
    endgenerate

    // Software-writable configuration registers
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            spin_q  <= '0;
            short_q <= '0;
            win_q   <= '0;
        end else if (w_wr) begin
            if (wr_addr == ADDR_W'(OFS_SPIN))  spin_q  <= wdata[NUM_CELLS-1:0];
            if (wr_addr == ADDR_W'(OFS_SHORT)) short_q <= wdata[NUM_CELLS-1:0];
            if (wr_addr == ADDR_W'(OFS_WIN))   win_q   <= wdata[CNT_W-1:0];
        end
    end

    // Two-flop synchroniser bringing each s-ring output into the clk domain
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            sync1_q  <= '0;
            sync_s_q <= '0;
        end else begin
            sync1_q  <= sout;
            sync_s_q <= sync1_q;
        end
    end

    // Measurement FSM: arm, count phase agreement with cell 0 over the window, flag done
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
            for (int i = 0; i < NUM_CELLS; i++) agree_q[i] <= '0;
        end else begin
            if (w_done_clr) done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_measure) state_q <= S_ARM;
                end
                S_ARM: begin
                    for (int i = 0; i < NUM_CELLS; i++) agree_q[i] <= '0;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    wcnt_q  <= win_q;
                    state_q <= (win_q == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    for (int i = 0; i < NUM_CELLS; i++) begin
                        if ((sync_s_q[i] == sync_s_q[0]) && (agree_q[i] != {CNT_W{1'b1}}))
                            agree_q[i] <= agree_q[i] + CNT_W'(1);
                    end
                    wcnt_q <= wcnt_q - CNT_W'(1);
                    if (wcnt_q == CNT_W'(1)) state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Combinational register read mux; anything unmapped reads as zero
    always_comb begin
        rdata = '0;
        if (rd_addr == ADDR_W'(OFS_SPIN))  rdata[NUM_CELLS-1:0] = spin_q;
        if (rd_addr == ADDR_W'(OFS_SHORT)) rdata[NUM_CELLS-1:0] = short_q;
        if (rd_addr == ADDR_W'(OFS_WIN))   rdata[CNT_W-1:0]     = win_q;
        if (rd_addr == ADDR_W'(OFS_STAT)) begin
            rdata[STAT_BUSY] = busy_q;
            rdata[STAT_DONE] = done_q;
        end
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (rd_addr == ADDR_W'(OFS_AGREE + i)) rdata[CNT_W-1:0] = agree_q[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shorted_cell_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_shorted_cell_bank
// Description : Scoreboard bench for shorted_cell_bank: stimulus pushes the
//               expected measurement result, a monitor pops it on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shorted_cell_bank;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int AW  = 6;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          axi_rstn = 1'b0;
    logic          ising_rstn = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  sin = '0;
    logic [N-1:0]  din = '0;
    logic [N-1:0]  sout;
    logic [N-1:0]  dout;
    logic          wready = 1'b0;
    logic          wr_addr_match = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wdata = '0;
    logic [AW-1:0] rd_addr = AW'(4);
    logic [31:0]   rdata;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int mon_cnt = 0;

    logic [N-1:0] m_spin  = '0;
    logic [N-1:0] m_short = '0;

    typedef struct {
        int exp_cyc;
        int agree [N];
    } meas_t;
    meas_t sb_q [$];

    shorted_cell_bank #(
        .NUM_CELLS (N),
        .NUM_LUTS  (2),
        .CNT_W     (CW),
        .ADDR_W    (AW)
    ) dut (
        .clk           (clk),
        .axi_rstn      (axi_rstn),
        .ising_rstn    (ising_rstn),
        .start         (start),
        .sin           (sin),
        .din           (din),
        .sout          (sout),
        .dout          (dout),
        .wready        (wready),
        .wr_addr_match (wr_addr_match),
        .wr_addr       (wr_addr),
        .wdata         (wdata),
        .rd_addr       (rd_addr),
        .rdata         (rdata)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference stage behaviour straight from the cell rules
    function automatic logic [N-1:0] model_s();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            logic s, d;
            s = ising_rstn & sin[i];
            d = ising_rstn & din[i];
            if (!start)         r[i] = m_spin[i];
            else if (m_short[i]) r[i] = ~(s & d);
            else                 r[i] = ~s;
        end
        return r;
    endfunction

    function automatic logic [N-1:0] model_d();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            logic s, d;
            s = ising_rstn & sin[i];
            d = ising_rstn & din[i];
            if (!start)         r[i] = m_spin[i];
            else if (m_short[i]) r[i] = ~(s & d);
            else                 r[i] = ~d;
        end
        return r;
    endfunction

    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clk);
        wready = 1'b1; wr_addr_match = 1'b1; wr_addr = AW'(a); wdata = d;
        @(posedge clk); #1;
        wready = 1'b0; wr_addr_match = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        @(negedge clk); #2;
        rd_addr = AW'(a);
        #1 v = rdata;
        rd_addr = AW'(4);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("sout", sout, model_s());
        chk("dout", dout, model_d());
    endtask

    // Start a measurement of window w; optionally poke MEASURE and WINDOW mid-run
    task automatic run_meas(input int w, input bit disturb);
        meas_t m;
        logic [N-1:0] s;
        logic [31:0] v;
        int t, target, k;
        wr(3, w);
        s = model_s();
        for (int i = 0; i < N; i++) m.agree[i] = (s[i] == s[0]) ? ((w > MAXC) ? MAXC : w) : 0;
        @(negedge clk);
        wready = 1'b1; wr_addr_match = 1'b1; wr_addr = AW'(2); wdata = 32'h1;
        @(posedge clk); #1;
        wready = 1'b0; wr_addr_match = 1'b0;
        t = cyc;
        m.exp_cyc = t + 2 + w;
        target = mon_cnt + 1;
        sb_q.push_back(m);
        @(posedge clk); @(negedge clk);
        chk("busy_after_arm", {31'd0, rdata[0]}, 32'd1);
        if (disturb && w >= 5) begin
            wr(2, 32'h1);
            wr(3, $urandom_range(0, MAXC));
        end
        k = 0;
        while (mon_cnt < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (mon_cnt < target) begin
            n_vec++; n_miss++;
            $display("FAIL done_timeout: got no done, expected done within window %0d", w);
        end
        repeat (3) @(negedge clk);
        rd(4, v);
        chk("status_after_done", v, 32'd2);
        wr(4, 32'h2);
        rd(4, v);
        chk("status_after_clear", v, 32'd0);
    endtask

    // Monitor: on each rising done, pop the expected result and compare
    initial begin : monitor
        logic prev, cur;
        meas_t m;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            cur = rdata[1];
            if (cur && !prev) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    m = sb_q.pop_front();
                    chk("done_cycle", cyc, m.exp_cyc);
                    for (int i = 0; i < N; i++) begin
                        #1 rd_addr = AW'(8 + i);
                        #1 chk($sformatf("agree%0d", i), rdata, m.agree[i]);
                    end
                    rd_addr = AW'(4);
                end
                mon_cnt++;
            end
            prev = cur;
        end
    end

    initial begin : stim
        logic [31:0] v;
        int offs [9] = '{0, 1, 2, 3, 4, 8, 9, 10, 11};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sout_reset", sout, '0);
        chk("dout_reset", dout, '0);
        axi_rstn = 1'b1;
        foreach (offs[j]) begin
            rd(offs[j], v);
            chk($sformatf("reset_reg%0d", offs[j]), v, 32'd0);
        end

        // Write without address match is ignored
        @(negedge clk);
        wready = 1'b1; wr_addr_match = 1'b0; wr_addr = AW'(0); wdata = 32'hF;
        @(posedge clk); #1 wready = 1'b0;
        rd(0, v);
        chk("spin_no_match", v, 32'd0);

        // Spin register drives outputs while rings are stopped
        wr(0, 32'hA); m_spin = 4'hA;
        settle(0);
        rd(0, v);
        chk("spin_read", v, 32'hA);

        // Independent vs shorted cell 2
        ising_rstn = 1'b1; start = 1'b1;
        sin = 4'b0100; din = 4'b0000;
        settle(1);
        wr(1, 32'h4); m_short = 4'h4;
        settle(1);
        rd(1, v);
        chk("short_read", v, 32'h4);

        // Static pattern 0101, window 10
        start = 1'b0;
        wr(0, 32'h5); m_spin = 4'h5;
        settle(3);
        run_meas(10, 1'b0);

        // Full window with a MEASURE/WINDOW poke mid-run, then all-equal
        run_meas(15, 1'b1);
        wr(0, 32'hF); m_spin = 4'hF;
        settle(3);
        run_meas(15, 1'b1);

        // Zero window
        run_meas(0, 1'b0);

        // Randomised configurations
        for (int it = 0; it < 12; it++) begin
            m_spin  = N'($urandom);
            m_short = N'($urandom);
            wr(0, m_spin);
            wr(1, m_short);
            @(negedge clk);
            start      = $urandom_range(0, 1);
            ising_rstn = $urandom_range(0, 1);
            sin        = N'($urandom);
            din        = N'($urandom);
            settle(3);
            run_meas($urandom_range(0, MAXC), $urandom_range(0, 1));
        end

        // Asynchronous reset mid-run clears everything at once
        start = 1'b0;
        wr(0, 32'h3); m_spin = 4'h3;
        repeat (3) @(posedge clk);
        wr(3, 15);
        wr(2, 32'h1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #3 axi_rstn = 1'b0;
        m_spin = '0; m_short = '0;
        #1 chk("status_async_rst", rdata, 32'd0);
        for (int i = 0; i < N; i++) begin
            rd_addr = AW'(8 + i);
            #1 chk($sformatf("agree%0d_async_rst", i), rdata, 32'd0);
        end
        rd_addr = AW'(4);
        chk("sout_async_rst", sout, '0);
        @(negedge clk);
        axi_rstn = 1'b1;
        repeat (20) @(negedge clk);
        rd(4, v);
        chk("status_after_rst", v, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
